crack_sched: RTL

Scheduler for the parallel ARC4 key search. It launches `NUM_ENG` `crack` engines on interleaved slices of the 24-bit keyspace: engine i starts at key i and steps by `NUM_ENG`. It watches every engine for completion and reports the first valid key found. On a hit, or on an external abort, it resets the engines that are still searching. It sits between the top-level control logic and the engine array.

---
 rtl/crack_sched_pkg.sv | 15 +
 rtl/crack_sched_if.sv | 36 +++
 rtl/crack_prio_enc.sv | 22 ++
 rtl/crack_sched.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/crack_sched_pkg.sv
// Shared types and constants for the ARC4 key-search scheduler.
package crack_pkg;

  localparam int unsigned KEY_W        = 24;
  localparam int unsigned ABORT_CYCLES = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StAbort,
    StDone
  } crack_sched_state_t;

endpackage

// File: rtl/crack_sched_if.sv
// Scheduler <-> engine-array bundle: launch/reset controls out, status and keys back.
interface crack_sched_if
  import crack_pkg::*;
#(
  parameter int unsigned NUM_ENG = 4
);

  logic [NUM_ENG-1:0]       eng_en;
  logic                     eng_rst_n;
  logic [NUM_ENG*KEY_W-1:0] eng_start_key;
  logic [KEY_W-1:0]         eng_step_key;
  logic [NUM_ENG-1:0]       eng_rdy;
  logic [NUM_ENG-1:0]       eng_key_valid;
  logic [NUM_ENG*KEY_W-1:0] eng_key;

  modport master (
    output eng_en,
    output eng_rst_n,
    output eng_start_key,
    output eng_step_key,
    input  eng_rdy,
    input  eng_key_valid,
    input  eng_key
  );

  modport slave (
    input  eng_en,
    input  eng_rst_n,
    input  eng_start_key,
    input  eng_step_key,
    output eng_rdy,
    output eng_key_valid,
    output eng_key
  );

endinterface

// File: rtl/crack_prio_enc.sv
// Lowest-index priority encoder: idx of the first set bit of req, hit if any bit is set.
module crack_prio_enc #(
  parameter int unsigned  Width = 4,
  localparam int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req,
  output logic [IdxW-1:0]  idx,
  output logic             hit
);

  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (req[i] && !hit) begin
        idx = IdxW'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crack_sched.sv
// Launches NUM_ENG interleaved key-search engines, reports the first valid key found and
// resets the remaining engines on a hit or an external abort.
module crack_sched
  import crack_pkg::*;
#(
  parameter int unsigned NUM_ENG = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [KEY_W-1:0] key_out,
  output logic [CNT_W-1:0] run_cycles,
  crack_sched_if.master    eng
);

  localparam int unsigned IdxW      = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int unsigned AbortCntW = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
  localparam logic [AbortCntW-1:0] AbortLast = AbortCntW'(ABORT_CYCLES - 1);

  crack_sched_state_t     state_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   found_q;
  logic [KEY_W-1:0]       key_q;
  logic [CNT_W-1:0]       run_q;
  logic [NUM_ENG-1:0]     eng_en_q;
  logic                   eng_rst_n_q;
  logic [NUM_ENG-1:0]     seen_busy_q;
  logic [AbortCntW-1:0]   abort_cnt_q;

  logic [NUM_ENG-1:0]     cmpl_vec;
  logic [NUM_ENG-1:0]     win_vec;
  logic [IdxW-1:0]        win_idx;
  logic                   win_hit;
  logic [KEY_W-1:0]       win_key;
  logic                   all_rdy;

  // An engine counts as complete only after it has been seen busy, so a stale
  // ready flag right after launch is never mistaken for a finished search.
  assign cmpl_vec = seen_busy_q & eng.eng_rdy;
  assign win_vec  = cmpl_vec & eng.eng_key_valid;
  assign all_rdy  = &eng.eng_rdy;

  crack_prio_enc #(
    .Width (NUM_ENG)
  ) u_prio_enc (
    .req (win_vec),
    .idx (win_idx),
    .hit (win_hit)
  );

  always_comb begin
    win_key = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      if (win_idx == IdxW'(i)) win_key = eng.eng_key[i*KEY_W +: KEY_W];
    end
  end

  always_comb begin
    eng.eng_start_key = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      eng.eng_start_key[i*KEY_W +: KEY_W] = KEY_W'(i);
    end
  end

  assign eng.eng_step_key = KEY_W'(NUM_ENG);
  assign eng.eng_en       = eng_en_q;
  assign eng.eng_rst_n    = eng_rst_n_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign key_out    = key_q;
  assign run_cycles = run_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      key_q       <= '0;
      run_q       <= '0;
      eng_en_q    <= '0;
      eng_rst_n_q <= 1'b0;
      seen_busy_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      done_q      <= 1'b0;
      eng_en_q    <= '0;
      eng_rst_n_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StLaunch;
            busy_q      <= 1'b1;
            found_q     <= 1'b0;
            key_q       <= '0;
            run_q       <= '0;
            seen_busy_q <= '0;
            if (all_rdy) eng_en_q <= '1;
          end
        end
        StLaunch: begin
          if (abort) begin
            state_q     <= StAbort;
            eng_rst_n_q <= 1'b0;
            abort_cnt_q <= '0;
          end else if (|eng_en_q) begin
            state_q <= StRun;
          end else if (all_rdy) begin
            eng_en_q <= '1;
          end
        end
        StRun: begin
          if (run_q != {CNT_W{1'b1}}) run_q <= run_q + CNT_W'(1);
          seen_busy_q <= seen_busy_q | ~eng.eng_rdy;
          // A winner takes precedence over a simultaneous abort.
          if (win_hit) begin
            state_q     <= StAbort;
            found_q     <= 1'b1;
            key_q       <= win_key;
            eng_rst_n_q <= 1'b0;
            abort_cnt_q <= '0;
          end else if (abort) begin
            state_q     <= StAbort;
            eng_rst_n_q <= 1'b0;
            abort_cnt_q <= '0;
          end else if (&cmpl_vec) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StAbort: begin
          if (abort_cnt_q == AbortLast) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            abort_cnt_q <= abort_cnt_q + AbortCntW'(1);
            eng_rst_n_q <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
